// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the operand issue stage and the 32-bit ALU.
//   DATA_W  : operand / result width
//   REG_CNT : number of architectural registers (register 0 reads as zero)
//   ADDR_W  : register index width, clog2(REG_CNT)
//   OP_W    : ALU opcode width
//   ALU_*   : opcode encodings; 3'b110 / 3'b111 are undefined and are passed
//             through untouched (the ALU produces 0 for them)
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_CNT = 32;
  localparam int ADDR_W  = $clog2(REG_CNT);
  localparam int OP_W    = 3;

  localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [OP_W-1:0] ALU_XOR = 3'b100;
  localparam logic [OP_W-1:0] ALU_NOR = 3'b101;

endpackage

// File: rtl/reg_file_2r1w.sv
// -----------------------------------------------------------------------------
// reg_file_2r1w
// Register file with two asynchronous read ports and one synchronous write
// port. Register 0 is hardwired to zero: writes to it are dropped and reads of
// it return 0. Contents are cleared by the asynchronous, active-high reset.
//   clk, rst          : clock / async active-high reset
//   we, waddr, wdata  : write port (takes effect on the rising edge)
//   raddr1 -> rdata1  : read port 1 (combinational)
//   raddr2 -> rdata2  : read port 2 (combinational)
// -----------------------------------------------------------------------------
module reg_file_2r1w #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] mem_q [REG_CNT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Entry 0 is never written, but the explicit zero keeps the read path
  // independent of that storage element.
  assign rdata1 = (raddr1 == '0) ? '0 : mem_q[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : mem_q[raddr2];

endmodule

// File: rtl/operand_issue_stage.sv
// -----------------------------------------------------------------------------
// operand_issue_stage
// Stage in front of the ALU: reads operands from the register file, tracks
// in-flight destinations with a busy-bit scoreboard, stalls on RAW hazards and
// latches A/B/opcode/destination into an output register. ALU results return
// through the writeback port.
//
// Ports:
//   clk, rst                  clock / asynchronous active-high reset
//   in_valid, in_ready        decode-side handshake
//   in_op, in_rs1, in_rs2     opcode and source registers
//   in_rd                     destination (0 = no writeback)
//   in_imm, in_use_imm        immediate and B-operand select
//   out_valid, out_ready      ALU-side handshake
//   alu_a, alu_b, alu_op      registered operands / opcode
//   out_rd                    destination carried to writeback
//   wb_en, wb_addr, wb_data   writeback of the ALU result
//
// Build option:
//   OPERAND_ISSUE_FWD_EN  when defined, a writeback in the same cycle as an
//                         issue read of the same nonzero register is forwarded
//                         into the operand and its busy bit is ignored for
//                         hazard purposes. When undefined, the instruction
//                         waits one more cycle and reads the written value.
// -----------------------------------------------------------------------------
module operand_issue_stage
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic [ADDR_W-1:0] out_rd,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  logic [DATA_W-1:0]  rdata1;
  logic [DATA_W-1:0]  rdata2;
  logic [REG_CNT-1:0] busy_q, busy_d;

  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  alu_a_q, alu_a_d;
  logic [DATA_W-1:0]  alu_b_q, alu_b_d;
  logic [OP_W-1:0]    alu_op_q, alu_op_d;
  logic [ADDR_W-1:0]  out_rd_q, out_rd_d;

  logic               wb_live;
  logic               fwd_a, fwd_b;
  logic               busy_rs1, busy_rs2;
  logic               hazard;
  logic               issue;
  logic [DATA_W-1:0]  opnd_a, opnd_b;

  reg_file_2r1w #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT),
    .ADDR_W  (ADDR_W)
  ) u_reg_file (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr1 (in_rs1),
    .rdata1 (rdata1),
    .raddr2 (in_rs2),
    .rdata2 (rdata2)
  );

  assign wb_live = wb_en && (wb_addr != '0);

`ifdef OPERAND_ISSUE_FWD_EN
  assign fwd_a = wb_live && (wb_addr == in_rs1);
  assign fwd_b = wb_live && (wb_addr == in_rs2);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  // A source being written back this cycle is not a hazard when it is
  // forwarded; without forwarding the busy bit still blocks until next cycle.
  assign busy_rs1 = busy_q[in_rs1] && (in_rs1 != '0) && !fwd_a;
  assign busy_rs2 = busy_q[in_rs2] && (in_rs2 != '0) && !fwd_b && !in_use_imm;
  assign hazard   = in_valid && (busy_rs1 || busy_rs2);

  // The output register can take a new instruction when empty or draining.
  assign in_ready = !rst && (!out_valid_q || out_ready) && !hazard;
  assign issue    = in_valid && in_ready;

  assign opnd_a = fwd_a ? wb_data : rdata1;
  assign opnd_b = in_use_imm ? in_imm : (fwd_b ? wb_data : rdata2);

  // Scoreboard: the issue's set is applied after the writeback's clear so that
  // a same-register collision leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (wb_live) begin
      busy_d[wb_addr] = 1'b0;
    end
    if (issue && (in_rd != '0)) begin
      busy_d[in_rd] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    out_rd_d    = out_rd_q;
    if (issue) begin
      out_valid_d = 1'b1;
      alu_a_d     = opnd_a;
      alu_b_d     = opnd_b;
      alu_op_d    = in_op;
      out_rd_d    = in_rd;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      out_rd_q    <= '0;
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      out_rd_q    <= out_rd_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign out_rd    = out_rd_q;

endmodule

// File: tb/tb_operand_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_operand_issue_stage
// Directed scenarios followed by randomized traffic, checked every cycle
// against a behavioural model: an array of register values, an array of busy
// flags and a single output slot. Works with or without OPERAND_ISSUE_FWD_EN.
// -----------------------------------------------------------------------------
module tb_operand_issue_stage;
  import alu_pkg::*;

`ifdef OPERAND_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [ADDR_W-1:0] in_rs1;
  logic [ADDR_W-1:0] in_rs2;
  logic [ADDR_W-1:0] in_rd;
  logic [DATA_W-1:0] in_imm;
  logic              in_use_imm;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [ADDR_W-1:0] out_rd;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  always #5 clk = ~clk;

  operand_issue_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_rd      (in_rd),
    .in_imm     (in_imm),
    .in_use_imm (in_use_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .out_rd     (out_rd),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_reg  [32];
  bit          m_busy [32];
  bit          m_ov;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_op;
  logic [4:0]  m_rd;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit fwd_hit(input logic [4:0] r);
    return FWD && wb_en && (wb_addr != 0) && (wb_addr == r);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 0) return 32'h0;
    if (fwd_hit(r)) return wb_data;
    return m_reg[r];
  endfunction

  function automatic bit m_blocked(input logic [4:0] r);
    return (r != 0) && m_busy[r] && !fwd_hit(r);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = 32'h0;
      m_busy[i] = 1'b0;
    end
    m_ov = 1'b0; m_a = 32'h0; m_b = 32'h0; m_op = 3'h0; m_rd = 5'h0;
  endtask

  task automatic check_outputs(input string pfx);
    check_val({pfx, "out_valid"}, 32'(out_valid), 32'(m_ov));
    check_val({pfx, "alu_a"},     alu_a,          m_a);
    check_val({pfx, "alu_b"},     alu_b,          m_b);
    check_val({pfx, "alu_op"},    32'(alu_op),    32'(m_op));
    check_val({pfx, "out_rd"},    32'(out_rd),    32'(m_rd));
  endtask

  // One clock cycle: inputs were driven just after a falling edge.
  task automatic step();
    bit          exp_ready, fire, hz;
    logic [31:0] a, b;
    #1;
    hz        = in_valid && (m_blocked(in_rs1) || (!in_use_imm && m_blocked(in_rs2)));
    exp_ready = (!m_ov || out_ready) && !hz;
    check_val("in_ready", 32'(in_ready), 32'(exp_ready));
    fire = in_valid && exp_ready;
    a    = m_read(in_rs1);
    b    = in_use_imm ? in_imm : m_read(in_rs2);
    @(posedge clk);
    #1;
    if (wb_en && wb_addr != 0) begin
      m_reg[wb_addr]  = wb_data;
      m_busy[wb_addr] = 1'b0;
    end
    if (fire) begin
      m_ov = 1'b1; m_a = a; m_b = b; m_op = in_op; m_rd = in_rd;
      if (in_rd != 0) m_busy[in_rd] = 1'b1;
      $display("issue t=%0t op=%0d a=%08h b=%08h rd=%0d", $time, in_op, a, b, in_rd);
    end else if (m_ov && out_ready) begin
      m_ov = 1'b0;
    end
    check_outputs("");
  endtask

  task automatic cyc(input bit v, input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic [31:0] imm, input bit use_imm, input bit ordy,
                     input bit wen, input logic [4:0] waddr, input logic [31:0] wdata);
    @(negedge clk);
    in_valid = v; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_imm = imm; in_use_imm = use_imm; out_ready = ordy;
    wb_en = wen; wb_addr = waddr; wb_data = wdata;
    step();
  endtask

  // Reset asserted between edges; outputs must clear without waiting for clk.
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_clear();
    check_outputs("rst_");
    check_val("rst_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [4:0] pick;
    rst = 1'b1;
    in_valid = 0; in_op = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_imm = 0; in_use_imm = 0;
    out_ready = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    model_clear();

    apply_reset();

    // Issue with all-zero operands
    cyc(1, ALU_ADD, 0, 0, 0, 32'h0, 0, 1, 0, 0, 32'h0);
    // Writeback r3=5, then issue r3 with immediate 7 into r4
    cyc(0, ALU_ADD, 0, 0, 0, 32'h0, 0, 1, 1, 3, 32'h5);
    cyc(1, ALU_SUB, 3, 0, 4, 32'h7, 1, 1, 0, 0, 32'h0);
    // RAW on r4: stalls until its writeback
    cyc(1, ALU_ADD, 4, 0, 5, 32'h0, 1, 1, 0, 0, 32'h0);
    cyc(1, ALU_ADD, 4, 0, 5, 32'h0, 1, 1, 0, 0, 32'h0);
    cyc(1, ALU_ADD, 4, 0, 5, 32'h0, 1, 1, 1, 4, 32'hC);
    cyc(1, ALU_ADD, 4, 0, 5, 32'h0, 1, 1, 0, 0, 32'h0);
    // Output held for 3 cycles, then back-to-back issues
    for (int i = 0; i < 3; i++) cyc(1, ALU_AND, 3, 0, 6, 32'h1, 1, 0, 0, 0, 32'h0);
    cyc(1, ALU_AND, 3, 0, 6, 32'h1, 1, 1, 0, 0, 32'h0);
    cyc(1, ALU_NOR, 3, 0, 7, 32'h2, 1, 1, 0, 0, 32'h0);
    // Write to r0 is ignored
    cyc(0, ALU_ADD, 0, 0, 0, 32'h0, 0, 1, 1, 0, 32'hFFFF_FFFF);
    cyc(1, ALU_OR,  0, 0, 0, 32'h0, 0, 1, 0, 0, 32'h0);
    // Reset in the middle of a stall with r4 busy and output occupied
    cyc(0, ALU_ADD, 0, 0, 0, 32'h0, 0, 1, 0, 0, 32'h0);
    cyc(1, ALU_XOR, 3, 0, 4, 32'h0, 1, 0, 0, 0, 32'h0);
    cyc(1, ALU_XOR, 4, 0, 8, 32'h0, 1, 0, 0, 0, 32'h0);
    apply_reset();
    cyc(1, ALU_ADD, 4, 0, 7, 32'h0, 1, 1, 0, 0, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) apply_reset();
      pick = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 32; k++) begin
          if (m_busy[(int'(pick) + k) % 32]) begin
            pick = 5'((int'(pick) + k) % 32);
            break;
          end
        end
      end
      cyc($urandom_range(0, 9) < 7,
          3'($urandom_range(0, 7)),
          5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)),
          $urandom(),
          $urandom_range(0, 2) == 0,
          $urandom_range(0, 9) < 7,
          $urandom_range(0, 9) < 4,
          pick,
          $urandom());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/operand_issue_stage.md
Name: operand_issue_stage

Overview:
- Pipeline stage directly upstream of the 32-bit ALU.
- Holds the 32x32 register file and a busy-bit scoreboard, and latches operands A/B plus the 3-bit ALU opcode into an output register.
- Accepts the ALU result back through a writeback port.
- Uses a valid/ready handshake on both sides, so the decode stage and the ALU/writeback stage can stall independently.

Parameters:
- DATA_W, 32, operand/result width; must match ALU width.
- REG_CNT, 32, number of architectural registers; register 0 is hardwired to zero.
- ADDR_W, 5, register index width; equals clog2(REG_CNT).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_op  in  3  ALU opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nor, 110/111 undefined.
- in_rs1  in  ADDR_W  source register for A.
- in_rs2  in  ADDR_W  source register for B.
- in_rd  in  ADDR_W  destination register; 0 means no writeback.
- in_imm  in  DATA_W  immediate value.
- in_use_imm  in  1  B comes from in_imm instead of rs2.
- out_valid  out  1  operands valid for the ALU.
- out_ready  in  1  downstream consumes this cycle.
- alu_a  out  DATA_W  operand A.
- alu_b  out  DATA_W  operand B.
- alu_op  out  3  opcode passed through to the ALU.
- out_rd  out  ADDR_W  destination carried forward to writeback.
- wb_en  in  1  writeback strobe.
- wb_addr  in  ADDR_W  writeback register.
- wb_data  in  DATA_W  writeback data (ALU result).

Behaviour:
- Reset (async, rst=1):
  - All registers, busy bits, out_valid, alu_a, alu_b, alu_op and out_rd are cleared to 0.
  - in_ready is held at 0 while rst=1.
  - Reset mid-operation drops any held instruction; no writeback from it occurs.
- Hazard term: hazard = in_valid & ((busy[rs1] & rs1!=0) | (!in_use_imm & busy[rs2] & rs2!=0)).
- in_ready = (!out_valid | out_ready) & !hazard. This is combinational and does not depend on in_valid beyond the hazard term.
- Issue fires when in_valid & in_ready. Next edge:
  - out_valid <= 1.
  - alu_a <= R[rs1].
  - alu_b <= in_use_imm ? in_imm : R[rs2].
  - alu_op <= in_op; out_rd <= in_rd.
  - busy[in_rd] <= 1 if in_rd != 0.
- Latency: one cycle from accepted input to out_valid.
- Output register behaviour:
  - When out_valid & out_ready and no new issue: out_valid <= 0.
  - When out_valid & !out_ready: all outputs hold stable.
- Writeback, when wb_en=1 and wb_addr != 0:
  - R[wb_addr] <= wb_data; busy[wb_addr] <= 0.
  - Writes to register 0 are ignored; a read of register 0 always returns 0.
- Simultaneous events:
  - Issue setting busy[x] and writeback clearing busy[x] in the same cycle: set wins, and the register is still written.
  - Writeback and read of the same register in the same cycle: see Optional Feature.
- Undefined opcodes 110/111 pass through unchanged; the ALU yields 0 for them.
- Arithmetic: none in this stage; all values are passed bit-exact.

Optional Feature:
- Macro: OPERAND_ISSUE_FWD_EN.
- Defined:
  - A writeback in the same cycle as an issue read of the same nonzero register forwards wb_data into alu_a/alu_b.
  - busy for that register is treated as clear when computing hazard, so there is no stall.
- Undefined:
  - The read returns the old register contents, and hazard still sees the busy bit set.
  - The instruction stalls one cycle and issues with the new value.

Decomposition:
- Shared package alu_pkg holds:
  - DATA_W, ADDR_W and REG_CNT.
  - ALU opcode constants ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR.
  - Opcode width 3.
- Natural sub-module: reg_file_2r1w.
  - Two async read ports and one sync write port.
  - Register 0 hardwired to zero.
  - Async reset of its contents.
- Scoreboard, hazard logic and output register stay in the top module.

Test Plan:
- Reset, then issue op=000 rs1=0 rs2=0 rd=0: out_valid=1 next cycle, alu_a=0, alu_b=0, alu_op=000, no busy bits set.
- Writeback wb_addr=3 wb_data=0x0000_0005, then issue rs1=3 use_imm=1 imm=0x7 op=001 rd=4 → alu_a=5, alu_b=7, alu_op=001, busy[4]=1.
- With busy[4]=1, issue rs1=4: in_ready=0 until wb_en addr=4 data=0xC.
  - With fwd: issues the same cycle with alu_a=0xC.
  - Without fwd: issues the next cycle with alu_a=0xC.
- Hold out_ready=0 for 3 cycles with an instruction latched: alu_a, alu_b, alu_op stable, in_ready=0; releasing out_ready with in_valid=1 accepts a back-to-back issue, and out_valid stays 1.
- wb_en addr=0 data=0xFFFF_FFFF, then read rs1=0: alu_a=0.
- Assert rst mid-stall with busy[4]=1 and out_valid=1: all outputs 0 immediately, busy cleared, and a subsequent rs1=4 issue proceeds without a stall.
